debounce_edge_bank: RTL and testbench

//  Parametrised multi-channel input conditioner: synchronises raw push-button/switch inputs and debounces them
//  on a shared sample tick. Emits a stable level per channel plus one-cycle rise/fall/change pulses in the

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_chan.sv | 98 +++++++++
 rtl/debounce_edge_bank.sv | 58 +++++
 tb/tb_debounce_edge_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_edge_bank input conditioner.
package debounce_pkg;

  localparam int DEF_TICK_DIV   = 10000;
  localparam int DEF_DEPTH      = 11;
  localparam int DEF_HOLD_TICKS = 1000;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int DEF_PRE_W  = clog2(DEF_TICK_DIV);
  localparam int DEF_CNT_W  = clog2(DEF_DEPTH);
  localparam int DEF_HOLD_W = clog2(DEF_HOLD_TICKS + 1);

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, sample counter, level and edge pulses.
// Optional long-press counter built when LONG_PRESS_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic MHz,
  input  logic Reset,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change,
  output logic hold
);

  localparam int CW = clog2(DEPTH);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_rise;
  logic          r_fall;
  logic          r_chg;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_last;

  assign w_diff = r_s2 ^ r_lvl;
  assign w_last = (r_cnt == CW'(DEPTH - 1));

  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_chg  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_chg  <= 1'b0;
      if (tick) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_last) begin
          r_lvl  <= r_s2;
          r_cnt  <= '0;
          r_rise <= r_s2;
          r_fall <= ~r_s2;
          r_chg  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign level  = r_lvl;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign change = r_chg;

`ifdef LONG_PRESS_EN
  localparam int HW = clog2(HOLD_TICKS + 1);

  logic [HW-1:0] r_hcnt;
  logic          r_hold;

  // Saturating at HOLD_TICKS makes the pulse fire once per press.
  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset) begin
      r_hcnt <= '0;
      r_hold <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (!r_lvl) begin
        r_hcnt <= '0;
      end else if (tick && r_hcnt != HW'(HOLD_TICKS)) begin
        r_hcnt <= r_hcnt + 1'b1;
        r_hold <= (r_hcnt == HW'(HOLD_TICKS - 1));
      end
    end
  end

  assign hold = r_hold;
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_edge_bank.sv
// Multi-channel debounce bank: shared sample prescaler plus CH channels.
// Define LONG_PRESS_EN to build the per-channel long-press hold pulse.
module debounce_edge_bank
  import debounce_pkg::*;
#(
  parameter int CH         = 4,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic          MHz,
  input  logic          Reset,
  input  logic [CH-1:0] din,
  output logic          tick,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] change,
  output logic [CH-1:0] hold
);

  localparam int PW = clog2(TICK_DIV);

  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign tick = w_tick;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_chan #(
      .DEPTH      (DEPTH),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .MHz    (MHz),
      .Reset  (Reset),
      .din    (din[g]),
      .tick   (w_tick),
      .level  (level[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .change (change[g]),
      .hold   (hold[g])
    );
  end

endmodule

// File: tb/tb_debounce_edge_bank.sv
// Directed bench for debounce_edge_bank (CH=2, TICK_DIV=4, DEPTH=3, HOLD_TICKS=5).
// Exercises the long-press path when LONG_PRESS_EN is defined.
module tb_debounce_edge_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] din = 2'b00;
  logic       tick;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] change;
  logic [1:0] hold;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [1:0] seen_pulse = 2'b00;
  logic [1:0] seen_hold = 2'b00;

  always #5 clk = ~clk;

  debounce_edge_bank #(
    .CH         (2),
    .TICK_DIV   (4),
    .DEPTH      (3),
    .HOLD_TICKS (5)
  ) dut (
    .MHz    (clk),
    .Reset  (rst_n),
    .din    (din),
    .tick   (tick),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .change (change),
    .hold   (hold)
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record any pulses seen there.
  task automatic step();
    @(negedge clk);
    seen_pulse = seen_pulse | rise | fall | change;
    seen_hold  = seen_hold | hold;
  endtask

  // Advance to the next falling edge on which tick is high.
  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (tick === 1'b1);
    end
    check("tick_timeout", {7'd0, got}, 8'd1);
  endtask

  initial begin
    int n;

    repeat (10) step();
    check("rst_level", level, 8'h0);
    check("rst_tick", tick, 8'h0);
    check("rst_pulses", rise | fall | change, 8'h0);
    check("rst_hold", hold, 8'h0);
    rst_n = 1'b1;

    step();
    step();
    check("tick_early", tick, 8'h0);
    step();
    check("first_tick", tick, 8'h1);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 20);
    check("tick_period", n[7:0], 8'd4);
    check("idle_level", level, 8'h0);

    // ch0 press
    seen_pulse = 2'b00;
    din[0] = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    check("pre_accept_lvl", level, 8'h0);
    step();
    check("acc_level", level, 8'h1);
    check("acc_rise", rise, 8'h1);
    check("acc_fall", fall, 8'h0);
    check("acc_change", change, 8'h1);
    step();
    check("rise_width", rise, 8'h0);
    check("chg_width", change, 8'h0);
    check("ch1_quiet", seen_pulse, 8'h1);

    // ch1 press
    wait_tick();
    din[1] = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    step();
    check("ch1_level", level, 8'h3);
    check("ch1_rise", rise, 8'h2);

    // two-sample glitch on ch0 is rejected
    wait_tick();
    seen_pulse = 2'b00;
    din[0] = 1'b0;
    wait_tick();
    wait_tick();
    din[0] = 1'b1;
    repeat (4) wait_tick();
    check("glitch_level", level, 8'h3);
    check("glitch_pulse", seen_pulse, 8'h0);

    // simultaneous fall; full DEPTH needed after the glitch
    din = 2'b00;
    wait_tick();
    wait_tick();
    check("no_early_fall", level, 8'h3);
    check("no_early_pulse", seen_pulse, 8'h0);
    wait_tick();
    check("pre_fall_lvl", level, 8'h3);
    step();
    check("fall_both", fall, 8'h3);
    check("fall_change", change, 8'h3);
    check("fall_norise", rise, 8'h0);
    check("fall_level", level, 8'h0);
    step();
    check("fall_width", fall, 8'h0);

    // reset mid-count with din[0] held high
    wait_tick();
    din[0] = 1'b1;
    wait_tick();
    wait_tick();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_level", level, 8'h0);
    check("midrst_pulse", rise | fall | change, 8'h0);
    check("midrst_tick", tick, 8'h0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    check("rerst_pre_lvl", level, 8'h0);
    step();
    check("rerst_level", level, 8'h1);
    check("rerst_rise", rise, 8'h1);
    step();

    // long press on ch1
    wait_tick();
    din[1] = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    step();
    check("lp_rise", rise, 8'h2);
    check("lp_level", level, 8'h3);
`ifdef LONG_PRESS_EN
    seen_hold = 2'b00;
    repeat (5) wait_tick();
    check("hold_early", {7'd0, seen_hold[1]}, 8'h0);
    step();
    check("hold_pulse", {7'd0, hold[1]}, 8'h1);
    step();
    check("hold_width", {7'd0, hold[1]}, 8'h0);
    seen_hold = 2'b00;
    repeat (8) wait_tick();
    check("hold_once", {7'd0, seen_hold[1]}, 8'h0);
    din[1] = 1'b0;
    repeat (4) wait_tick();
    check("rel_level", {7'd0, level[1]}, 8'h0);
    din[1] = 1'b1;
    repeat (8) wait_tick();
    step();
    check("rehold_pulse", {7'd0, hold[1]}, 8'h1);
`else
    repeat (10) wait_tick();
    check("hold_off", seen_hold, 8'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
